vend_order_entry: RTL and testbench
===================================

VEND_ORDER_ENTRY -- requirements
Module: vend_order_entry

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: idle cycles in COLLECT before an automatic refund.
REQ-002 Parameter MAX_MONEY, default 15: credit ceiling; must fit 4 bits.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port coin_valid, input, 1: one-cycle coin-insert strobe.
REQ-006 Port coin_code, input, 2: coin value code; 00=1, 01=2, 10=5, 11=invalid.
REQ-007 Port sel_valid, input, 1: item-select strobe.
REQ-008 Port item_sel, input, 2: item index into the price table.
REQ-009 Port qty_inc, input, 1: strobe that increments quantity.
REQ-010 Port confirm / cancel, input, 1 each: user commit / abort strobes.
REQ-011 Port req_ready, input, 1: downstream purchase stage accepts the request.
REQ-012 Port money / price / amount, output, 4 each: credit, unit price, quantity; feed the purchase stage.
REQ-013 Port req_valid, output, 1: purchase request valid.
REQ-014 Port refund_valid, output, 1 / refund_amt, output, 4: one-cycle refund pulse and its value.
REQ-015 Port coin_reject, output, 1: one-cycle pulse when a coin is refused.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, REQUEST, REFUND.
REQ-017 Coin accept: money <= money + value when the sum <= MAX_MONEY; otherwise, or for code 11, money holds and coin_reject pulses on the next cycle.
REQ-018 IDLE: first accepted coin or sel_valid -> COLLECT.
REQ-019 sel_valid in IDLE/COLLECT: price <= table[item_sel], amount <= 1; reselect overwrites both.
REQ-020 qty_inc in COLLECT with an item selected: amount +1, saturating at 15.
REQ-021 confirm in COLLECT with amount != 0 -> REQUEST next cycle; confirm with no item selected is ignored.
REQ-022 REQUEST: req_valid=1; money/price/amount held stable until req_valid && req_ready; then -> IDLE with money/price/amount cleared.
REQ-023 REQUEST: coins are rejected (coin_reject); cancel, qty_inc, and sel_valid are ignored.
REQ-024 cancel in COLLECT -> REFUND; REFUND lasts 1 cycle with refund_valid=1, refund_amt=money; then IDLE with all registers cleared.
REQ-025 Timeout counter: resets on any strobe in COLLECT; at TIMEOUT_CYC consecutive quiet cycles -> REFUND.
REQ-026 Same cycle cancel + coin: cancel wins, coin rejected, refund excludes that coin.
REQ-027 Same cycle cancel + confirm: cancel wins.
REQ-028 Same cycle coin + confirm: coin accepted, and the request carries the updated money.
REQ-029 refund with money=0 still pulses refund_valid with refund_amt=0.
REQ-030 Latency: strobe-to-output effect SHALL be exactly 1 cycle; no combinational path from inputs to outputs.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, money=price=amount=0, req_valid=0, refund_valid=0, refund_amt=0, coin_reject=0, and the timeout counter to 0.
REQ-032 Reset during COLLECT or REQUEST SHALL discard credit without a refund pulse.

Structure
REQ-033 Package vend_pkg SHALL hold the coin code constants, the coin value table, the 4-entry price table (3,4,6,9), and the state encoding.
REQ-034 The timeout counter SHALL be the sub-module vend_timeout_ctr, with inputs clear, enable, and rst, and an expired output.

Verification
REQ-035 Coins 5,1; select item 0; qty_inc; confirm; req_ready=1 -> req_valid with money=6, price=3, amount=2; IDLE next cycle.
REQ-036 Coins 5,5,5 then coin 1 -> money=15, coin_reject pulses once, money stays 15.
REQ-037 Coins 2,2 then cancel -> one-cycle refund_valid with refund_amt=4; money=0.
REQ-038 Coin 1, no further input for 255 cycles -> refund_amt=1 at cycle 256.
REQ-039 In REQUEST with req_ready=0 for 10 cycles, then coin + cancel -> outputs stable, coin_reject=1, no refund.
REQ-040 rst asserted mid-COLLECT with money=7 -> all outputs 0 asynchronously, refund_valid never asserted.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared constants, tables and types for the vending order-entry block.
package vend_pkg;

    localparam int unsigned MONEY_W = 4;
    localparam int unsigned CODE_W  = 2;

    // Coin codes as presented on coin_code
    localparam logic [CODE_W-1:0] COIN_1   = 2'b00;
    localparam logic [CODE_W-1:0] COIN_2   = 2'b01;
    localparam logic [CODE_W-1:0] COIN_5   = 2'b10;
    localparam logic [CODE_W-1:0] COIN_BAD = 2'b11;

    // Unit price per item index; entry 0 is the rightmost element
    localparam logic [3:0][MONEY_W-1:0] PRICE_TABLE = {4'd9, 4'd6, 4'd4, 4'd3};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REQUEST = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    // Order payload handed to the purchase stage
    typedef struct packed {
        logic [MONEY_W-1:0] money;
        logic [MONEY_W-1:0] price;
        logic [MONEY_W-1:0] amount;
    } order_t;

    // Coin value table; the invalid code is worth nothing
    function automatic logic [MONEY_W-1:0] coin_value(input logic [CODE_W-1:0] code);
        case (code)
            COIN_1:  return MONEY_W'(1);
            COIN_2:  return MONEY_W'(2);
            COIN_5:  return MONEY_W'(5);
            default: return MONEY_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Quiet-cycle counter; expired means the current quiet cycle completes the timeout.
module vend_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_expired;

    // Next count: clear wins, otherwise count up and saturate at the last value
    always_comb begin
        w_count_nxt = r_count;
        if (clear) begin
            w_count_nxt = '0;
        end else if (enable && (r_count != LAST)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // Count and registered expiry flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_expired <= (w_count_nxt == LAST);
        end
    end

    assign expired = r_expired;

endmodule

// File: rtl/vend_order_entry.sv
// Vending order entry: coin credit, item/quantity selection, purchase request and refund.
module vend_order_entry
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned MAX_MONEY   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [CODE_W-1:0]  coin_code,
    input  logic               sel_valid,
    input  logic [1:0]         item_sel,
    input  logic               qty_inc,
    input  logic               confirm,
    input  logic               cancel,
    input  logic               req_ready,
    output logic [MONEY_W-1:0] money,
    output logic [MONEY_W-1:0] price,
    output logic [MONEY_W-1:0] amount,
    output logic               req_valid,
    output logic               refund_valid,
    output logic [MONEY_W-1:0] refund_amt,
    output logic               coin_reject
);

    state_t             r_state, w_next_state;
    order_t             r_order, w_order;
    logic               r_req_valid, w_req_valid;
    logic               r_refund_valid, w_refund_valid;
    logic [MONEY_W-1:0] r_refund_amt, w_refund_amt;
    logic               r_coin_reject, w_coin_reject;

    logic               w_any_strobe;
    logic               w_in_entry;
    logic [MONEY_W:0]   w_coin_sum;
    logic               w_coin_accept;
    logic               w_expired;
    logic               w_timeout;

    assign w_any_strobe  = coin_valid | sel_valid | qty_inc | confirm | cancel;
    assign w_in_entry    = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
    assign w_coin_sum    = {1'b0, r_order.money} + {1'b0, coin_value(coin_code)};
    // A cancel in COLLECT refuses a coin arriving in the same cycle
    assign w_coin_accept = coin_valid && w_in_entry && (coin_code != COIN_BAD)
                         && (w_coin_sum <= (MONEY_W+1)'(MAX_MONEY))
                         && !((r_state == ST_COLLECT) && cancel);
    assign w_timeout     = (r_state == ST_COLLECT) && w_expired && !w_any_strobe;

    vend_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   ((r_state != ST_COLLECT) || w_any_strobe),
        .enable  (r_state == ST_COLLECT),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; cancel outranks timeout and confirm
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_coin_accept || sel_valid) w_next_state = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (cancel || w_timeout) begin
                    w_next_state = ST_REFUND;
                end else if (confirm && (r_order.amount != '0)) begin
                    w_next_state = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (r_req_valid && req_ready) w_next_state = ST_IDLE;
            end
            ST_REFUND: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Next values of the order payload and the pulse outputs
    always_comb begin
        w_order        = r_order;
        w_req_valid    = r_req_valid;
        w_refund_valid = 1'b0;
        w_refund_amt   = '0;
        w_coin_reject  = coin_valid && !w_coin_accept;

        if (w_coin_accept) begin
            w_order.money = w_coin_sum[MONEY_W-1:0];
        end

        if (sel_valid && w_in_entry) begin
            w_order.price  = PRICE_TABLE[item_sel];
            w_order.amount = MONEY_W'(1);
        end else if (qty_inc && (r_state == ST_COLLECT)
                     && (r_order.amount != '0) && (r_order.amount != '1)) begin
            w_order.amount = r_order.amount + MONEY_W'(1);
        end

        case (r_state)
            ST_COLLECT: begin
                if (w_next_state == ST_REFUND) begin
                    w_refund_valid = 1'b1;
                    w_refund_amt   = r_order.money;
                end else if (w_next_state == ST_REQUEST) begin
                    w_req_valid = 1'b1;
                end
            end
            ST_REQUEST: begin
                if (r_req_valid && req_ready) begin
                    w_order     = '0;
                    w_req_valid = 1'b0;
                end
            end
            ST_REFUND: w_order = '0;
            default:   ;
        endcase
    end

    // Output and payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_order        <= '0;
            r_req_valid    <= 1'b0;
            r_refund_valid <= 1'b0;
            r_refund_amt   <= '0;
            r_coin_reject  <= 1'b0;
        end else begin
            r_order        <= w_order;
            r_req_valid    <= w_req_valid;
            r_refund_valid <= w_refund_valid;
            r_refund_amt   <= w_refund_amt;
            r_coin_reject  <= w_coin_reject;
        end
    end

    assign money        = r_order.money;
    assign price        = r_order.price;
    assign amount       = r_order.amount;
    assign req_valid    = r_req_valid;
    assign refund_valid = r_refund_valid;
    assign refund_amt   = r_refund_amt;
    assign coin_reject  = r_coin_reject;

endmodule

// File: tb/tb_vend_order_entry.sv
// Scoreboard bench for vend_order_entry.
module tb_vend_order_entry;

    typedef struct packed {
        logic [3:0] money;
        logic [3:0] price;
        logic [3:0] amount;
    } req_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] item_sel = 2'b00;
    logic       qty_inc = 1'b0;
    logic       confirm = 1'b0;
    logic       cancel = 1'b0;
    logic       req_ready = 1'b0;
    logic [3:0] money, price, amount, refund_amt;
    logic       req_valid, refund_valid, coin_reject;

    int n_checks = 0;
    int n_errors = 0;

    req_exp_t   q_req[$];
    logic [3:0] q_refund[$];
    bit         q_rej[$];

    vend_order_entry dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_code    (coin_code),
        .sel_valid    (sel_valid),
        .item_sel     (item_sel),
        .qty_inc      (qty_inc),
        .confirm      (confirm),
        .cancel       (cancel),
        .req_ready    (req_ready),
        .money        (money),
        .price        (price),
        .amount       (amount),
        .req_valid    (req_valid),
        .refund_valid (refund_valid),
        .refund_amt   (refund_amt),
        .coin_reject  (coin_reject)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: pop and compare whenever the DUT emits an event
    task automatic sample();
        req_exp_t e;
        logic [3:0] r;
        if (req_valid && req_ready) begin
            if (q_req.size() == 0) chk("req_unexpected", 1, 0);
            else begin
                e = q_req.pop_front();
                chk("req_money", int'(money), int'(e.money));
                chk("req_price", int'(price), int'(e.price));
                chk("req_amount", int'(amount), int'(e.amount));
            end
        end
        if (refund_valid) begin
            if (q_refund.size() == 0) chk("refund_unexpected", int'(refund_valid), 0);
            else begin
                r = q_refund.pop_front();
                chk("refund_amt", int'(refund_amt), int'(r));
            end
        end
        if (coin_reject) begin
            if (q_rej.size() == 0) chk("reject_unexpected", int'(coin_reject), 0);
            else void'(q_rej.pop_front());
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [3:0] m, input logic [3:0] p, input logic [3:0] a);
        req_exp_t e;
        e.money = m; e.price = p; e.amount = a;
        q_req.push_back(e);
    endtask

    task automatic coin(input logic [1:0] c, input bit rej);
        coin_valid = 1'b1; coin_code = c;
        if (rej) q_rej.push_back(1'b1);
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic sel(input logic [1:0] s);
        sel_valid = 1'b1; item_sel = s;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel(input logic [3:0] exp_amt);
        q_refund.push_back(exp_amt);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_refund_valid", int'(refund_valid), 1);
        chk("cancel_refund_amt", int'(refund_amt), int'(exp_amt));
        tick();
        chk("cancel_refund_off", int'(refund_valid), 0);
        chk("cancel_money_clr", int'(money), 0);
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        #3;
        chk("rst_money", int'(money), 0);
        chk("rst_price", int'(price), 0);
        chk("rst_amount", int'(amount), 0);
        chk("rst_req_valid", int'(req_valid), 0);
        chk("rst_refund_valid", int'(refund_valid), 0);
        chk("rst_refund_amt", int'(refund_amt), 0);
        chk("rst_coin_reject", int'(coin_reject), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic purchase: 5+1, item 0, qty 2
        coin(2'b10, 0); coin(2'b00, 0);
        chk("buy_money", int'(money), 6);
        sel(2'd0);
        chk("buy_price", int'(price), 3);
        chk("buy_amount1", int'(amount), 1);
        qty_inc = 1'b1; tick(); qty_inc = 1'b0;
        chk("buy_amount2", int'(amount), 2);
        req_ready = 1'b1;
        push_req(4'd6, 4'd3, 4'd2);
        confirm = 1'b1; tick(); confirm = 1'b0;
        chk("buy_req_valid", int'(req_valid), 1);
        tick();
        chk("buy_req_done", int'(req_valid), 0);
        chk("buy_money_clr", int'(money), 0);
        chk("buy_amount_clr", int'(amount), 0);
        req_ready = 1'b0;

        // Credit ceiling
        coin(2'b10, 0); coin(2'b10, 0); coin(2'b10, 0);
        chk("cap_money15", int'(money), 15);
        coin(2'b00, 1);
        chk("cap_reject", int'(coin_reject), 1);
        chk("cap_money_hold", int'(money), 15);
        tick();
        chk("cap_reject_once", int'(coin_reject), 0);
        do_cancel(4'd15);

        // Cancel refund
        coin(2'b01, 0); coin(2'b01, 0);
        do_cancel(4'd4);

        // Invalid coin, reselect, quantity saturation, zero refund
        coin(2'b11, 1);
        chk("bad_reject", int'(coin_reject), 1);
        chk("bad_money", int'(money), 0);
        sel(2'd3);
        chk("sel3_price", int'(price), 9);
        sel(2'd2);
        chk("resel_price", int'(price), 6);
        chk("resel_amount", int'(amount), 1);
        for (int i = 0; i < 16; i++) begin
            qty_inc = 1'b1; tick(); qty_inc = 1'b0;
        end
        chk("qty_sat", int'(amount), 15);
        do_cancel(4'd0);

        // Confirm without item is ignored; then coin+confirm in one cycle
        coin(2'b00, 0);
        confirm = 1'b1; tick(); confirm = 1'b0;
        chk("noitem_confirm", int'(req_valid), 0);
        sel(2'd1);
        push_req(4'd3, 4'd4, 4'd1);
        coin_valid = 1'b1; coin_code = 2'b01; confirm = 1'b1;
        tick();
        coin_valid = 1'b0; confirm = 1'b0;
        chk("cc_req_valid", int'(req_valid), 1);
        chk("cc_money", int'(money), 3);

        // Stall in REQUEST, then coin+cancel and edits are ignored
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", int'(req_valid), 1);
            chk("stall_money", int'(money), 3);
            chk("stall_price", int'(price), 4);
            chk("stall_amount", int'(amount), 1);
        end
        q_rej.push_back(1'b1);
        coin_valid = 1'b1; coin_code = 2'b00; cancel = 1'b1;
        tick();
        coin_valid = 1'b0; cancel = 1'b0;
        chk("req_coin_reject", int'(coin_reject), 1);
        chk("req_no_refund", int'(refund_valid), 0);
        chk("req_money_hold", int'(money), 3);
        qty_inc = 1'b1; sel_valid = 1'b1; item_sel = 2'd3;
        tick();
        qty_inc = 1'b0; sel_valid = 1'b0;
        chk("req_price_hold", int'(price), 4);
        chk("req_amount_hold", int'(amount), 1);
        chk("req_valid_hold", int'(req_valid), 1);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("req_release", int'(req_valid), 0);
        chk("req_money_clr", int'(money), 0);

        // Cancel beats confirm
        coin(2'b10, 0); sel(2'd0);
        q_refund.push_back(4'd5);
        cancel = 1'b1; confirm = 1'b1;
        tick();
        cancel = 1'b0; confirm = 1'b0;
        chk("cxc_refund", int'(refund_valid), 1);
        chk("cxc_no_req", int'(req_valid), 0);
        tick();

        // Cancel beats coin; refund excludes the coin
        coin(2'b01, 0);
        q_rej.push_back(1'b1);
        q_refund.push_back(4'd2);
        coin_valid = 1'b1; coin_code = 2'b00; cancel = 1'b1;
        tick();
        coin_valid = 1'b0; cancel = 1'b0;
        chk("cxn_refund_amt", int'(refund_amt), 2);
        chk("cxn_reject", int'(coin_reject), 1);
        tick();
        chk("cxn_money_clr", int'(money), 0);

        // Inactivity timeout
        coin(2'b00, 0);
        q_refund.push_back(4'd1);
        n = 0;
        while (n < 400 && !refund_valid) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 255);
        chk("timeout_amt", int'(refund_amt), 1);
        tick();
        chk("timeout_money_clr", int'(money), 0);

        // Asynchronous reset mid-collect drops credit silently
        coin(2'b10, 0); coin(2'b01, 0);
        chk("pre_rst_money", int'(money), 7);
        #2 rst = 1'b1;
        #1;
        chk("arst_money", int'(money), 0);
        chk("arst_price", int'(price), 0);
        chk("arst_amount", int'(amount), 0);
        chk("arst_req_valid", int'(req_valid), 0);
        chk("arst_refund_valid", int'(refund_valid), 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_refund", int'(refund_valid), 0);
        chk("post_rst_money", int'(money), 0);

        tick(); tick();
        chk("q_req_empty", q_req.size(), 0);
        chk("q_refund_empty", q_refund.size(), 0);
        chk("q_rej_empty", q_rej.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
